// File: rtl/gpr_wb_pkg.sv
// Shared types and widths for the GPR writeback arbiter.
// Writeback entries pair a destination register with its result.
package gpr_wb_pkg;

  localparam int WORD    = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_GPR = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Load-result FIFO with occupancy count.
// Pointers wrap modulo DEPTH; push when full is ignored.
import gpr_wb_pkg::*;

module gpr_wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = $bits(wb_entry_t),
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: ALU priority, buffered loads, busy scoreboard.
// Option GPR_WB_R0_DISCARD_EN: results to r0 are consumed without a write.
import gpr_wb_pkg::*;

module gpr_wb_arbiter #(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 8,
  parameter  int WORD         = gpr_wb_pkg::WORD,
  parameter  int ADDR_W       = gpr_wb_pkg::ADDR_W,
  localparam int CW           = $clog2(DEPTH) + 1,
  localparam int SW           = $clog2(STARVE_LIMIT + 1),
  localparam int EW           = ADDR_W + WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [WORD-1:0]    alu_data,
  output logic               alu_stall,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [WORD-1:0]    ld_data,
  input  logic               issue_valid,
  input  logic [ADDR_W-1:0]  issue_addr,
  output logic [NUM_GPR-1:0] busy_mask,
  output logic [CW-1:0]      fifo_count,
  output logic               we,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [WORD-1:0]    wr_data
);

  logic [EW-1:0]      head;
  logic [ADDR_W-1:0]  head_addr;
  logic [WORD-1:0]    head_data;
  logic               full, empty;
  logic               push, pop, sel_alu;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WORD-1:0]    sel_data;
  logic               wr_en;
  logic               starving, hit;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic               stall_q, stall_d;
  logic [NUM_GPR-1:0] busy_q, busy_d;
  logic [NUM_GPR-1:0] set_m, clr_m;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD-1:0]    data_q, data_d;

  assign ld_ready = (fifo_count < CW'(DEPTH));
  assign push     = ld_valid && ld_ready;

  gpr_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({ld_addr, ld_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_addr = head[EW-1 -: ADDR_W];
  assign head_data = head[WORD-1:0];

  // A stall cycle forces the load path even if ALU misbehaves.
  assign sel_alu = alu_valid && !stall_q;
  assign pop     = !empty && (stall_q || !alu_valid);

  assign sel_addr = sel_alu ? alu_addr : head_addr;
  assign sel_data = sel_alu ? alu_data : head_data;

`ifdef GPR_WB_R0_DISCARD_EN
  assign wr_en = (sel_alu || pop) && (sel_addr != '0);
`else
  assign wr_en = sel_alu || pop;
`endif

  // Starvation counter and one-cycle stall request.
  always_comb begin
    starving = full && alu_valid;
    hit      = starving && (scnt_q == SW'(STARVE_LIMIT - 1));
    scnt_d   = '0;
    if (starving && !hit) scnt_d = scnt_q + SW'(1);
    stall_d  = hit;
  end

  // Busy scoreboard: set wins over clear, r0 never busy.
  always_comb begin
    set_m  = '0;
    clr_m  = '0;
    if (issue_valid) set_m = NUM_GPR'(1) << issue_addr;
    if (pop)         clr_m = NUM_GPR'(1) << head_addr;
    busy_d = ((busy_q & ~clr_m) | set_m) & ~NUM_GPR'(1);
  end

  // Write-port next state; idle cycles hold address and data.
  always_comb begin
    we_d   = wr_en;
    addr_d = addr_q;
    data_d = data_q;
    if (sel_alu || pop) begin
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // All arbiter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q  <= '0;
      stall_q <= 1'b0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      scnt_q  <= scnt_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign alu_stall = stall_q;
  assign busy_mask = busy_q;
  assign we        = we_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;

  a_no_alu_in_stall : assert property (
    @(posedge clk) disable iff (!rst) !(alu_stall && alu_valid)
  ) else $error("alu_valid asserted during alu_stall");

endmodule
